// File: rtl/mem_port_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
// Arbiter state, grant source and a saturating counter helper.
package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } req_src_e;

    localparam int unsigned AW_DEF         = 32;
    localparam int unsigned DW_DEF         = 32;
    localparam int unsigned TIMEOUT_DEF    = 16;
    localparam int unsigned STARVE_MAX_DEF = 3;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Busy-cycle timer for the memory port arbiter.
// Counts while enabled; expired is raised when the count hits TIMEOUT-1.
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    logic [CW-1:0] count;

    assign expired = (count == CW'(TIMEOUT - 1));

    // Cycle counter: cleared while idle, held once expired
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of a single-ported unified memory.
// Optional perf counters are built when MEM_PORT_ARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_ack,
    output logic [DW-1:0]   i_rdata,
    output logic            i_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wmask,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            d_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata,
    output logic            stall_if,
    output logic            stall_mem
`ifdef MEM_PORT_ARB_PERF_EN
    ,
    output logic [31:0]     perf_conflict,
    output logic [31:0]     perf_i_wait,
    output logic [31:0]     perf_timeout
`endif
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    arb_state_e     state, state_nxt;
    req_src_e       grant_src;
    logic           grant;
    logic           busy;
    logic           done;
    logic           expired;
    logic           starve_hit;
    logic [SW-1:0]  starve_cnt, starve_nxt;

    logic            i_ack_nxt, d_ack_nxt;
    logic            i_err_nxt, d_err_nxt;
    logic [DW-1:0]   i_rdata_nxt, d_rdata_nxt;
    logic            mem_req_nxt, mem_we_nxt;
    logic [AW-1:0]   mem_addr_nxt;
    logic [DW-1:0]   mem_wdata_nxt;
    logic [DW/8-1:0] mem_wmask_nxt;

    assign busy       = (state != IDLE);
    assign done       = busy && (mem_ack || expired);
    assign starve_hit = i_req && (starve_cnt == SW'(STARVE_MAX));
    assign stall_if   = i_req && !i_ack;
    assign stall_mem  = d_req && !d_ack;

    arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (!busy),
        .en     (busy),
        .expired(expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant decision in IDLE, completion detection while busy
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_src = SRC_I;
        unique case (state)
            IDLE: begin
                if (d_req && !starve_hit) begin
                    state_nxt = BUSY_D;
                    grant     = 1'b1;
                    grant_src = SRC_D;
                end else if (i_req) begin
                    state_nxt = BUSY_I;
                    grant     = 1'b1;
                    grant_src = SRC_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack || expired) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and starve counter
    always_comb begin
        i_ack_nxt     = done && (state == BUSY_I);
        d_ack_nxt     = done && (state == BUSY_D);
        i_err_nxt     = i_ack_nxt && !mem_ack;
        d_err_nxt     = d_ack_nxt && !mem_ack;
        i_rdata_nxt   = i_rdata;
        d_rdata_nxt   = d_rdata;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_wmask_nxt = mem_wmask;
        starve_nxt    = starve_cnt;
        if (i_ack_nxt) begin
            i_rdata_nxt = mem_ack ? mem_rdata : '0;
        end
        if (d_ack_nxt) begin
            d_rdata_nxt = (mem_ack && !mem_we) ? mem_rdata : '0;
        end
        if (done) begin
            mem_req_nxt = 1'b0;
        end
        if (grant) begin
            mem_req_nxt = 1'b1;
            if (grant_src == SRC_D) begin
                mem_we_nxt    = d_we;
                mem_addr_nxt  = d_addr;
                mem_wdata_nxt = d_wdata;
                mem_wmask_nxt = d_wmask;
                if (!i_req) begin
                    starve_nxt = '0;
                end else if (!starve_hit) begin
                    starve_nxt = starve_cnt + SW'(1);
                end
            end else begin
                mem_we_nxt    = 1'b0;
                mem_addr_nxt  = i_addr;
                mem_wdata_nxt = '0;
                mem_wmask_nxt = '1;
                starve_nxt    = '0;
            end
        end
    end

    // Output and request-field registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_err      <= 1'b0;
            d_err      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            starve_cnt <= '0;
        end else begin
            i_ack      <= i_ack_nxt;
            d_ack      <= d_ack_nxt;
            i_err      <= i_err_nxt;
            d_err      <= d_err_nxt;
            i_rdata    <= i_rdata_nxt;
            d_rdata    <= d_rdata_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            mem_wmask  <= mem_wmask_nxt;
            starve_cnt <= starve_nxt;
        end
    end

`ifdef MEM_PORT_ARB_PERF_EN
    // Saturating event counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_conflict <= '0;
            perf_i_wait   <= '0;
            perf_timeout  <= '0;
        end else begin
            if (state == IDLE && i_req && d_req) begin
                perf_conflict <= sat_inc(perf_conflict);
            end
            if (stall_if) begin
                perf_i_wait <= sat_inc(perf_i_wait);
            end
            if (done && !mem_ack) begin
                perf_timeout <= sat_inc(perf_timeout);
            end
        end
    end
`endif

    a_i_hold: assert property (@(posedge clk) disable iff (!rst)
        (state == BUSY_I) |-> i_req);
    a_d_hold: assert property (@(posedge clk) disable iff (!rst)
        (state == BUSY_D) |-> d_req);
    a_one_ack: assert property (@(posedge clk) disable iff (!rst)
        !(i_ack && d_ack));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a simple latency-programmable memory.
// Perf counter checks are compiled when MEM_PORT_ARB_PERF_EN is defined.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wmask = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall_if;
    logic        stall_mem;
`ifdef MEM_PORT_ARB_PERF_EN
    logic [31:0] perf_conflict;
    logic [31:0] perf_i_wait;
    logic [31:0] perf_timeout;
`endif

    int checks = 0;
    int errors = 0;

    int          mem_lat = 1;
    bit          mem_mute = 1'b0;
    logic [31:0] mem_val = '0;
    int          mem_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(16), .STARVE_MAX(3)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wmask(d_wmask), .d_ack(d_ack),
        .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef MEM_PORT_ARB_PERF_EN
        ,
        .perf_conflict(perf_conflict),
        .perf_i_wait(perf_i_wait),
        .perf_timeout(perf_timeout)
`endif
    );

    // Memory model: acks mem_lat cycles into a request (1 = same cycle as mem_req)
    always begin
        @(posedge clk);
        #1;
        if (mem_req && !mem_ack && !mem_mute) begin
            mem_cnt = mem_cnt + 1;
            if (mem_cnt >= mem_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_val;
            end
        end else begin
            mem_ack = 1'b0;
            mem_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        checks++; if ({mem_req, i_ack, d_ack, i_err, d_err} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {mem_req, i_ack, d_ack, i_err, d_err}); end
        checks++; if ({i_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {i_rdata, d_rdata}); end
        checks++; if ({mem_we, mem_addr, mem_wdata, mem_wmask} !== 69'h0) begin errors++; $display("FAIL reset_mem_fields: got %h want 0", {mem_we, mem_addr, mem_wdata, mem_wmask}); end
        checks++; if ({stall_if, stall_mem} !== 2'b00) begin errors++; $display("FAIL reset_stall: got %b want 00", {stall_if, stall_mem}); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        int cyc = 0;
        int st = 0;
        bit got = 0;
        mem_lat = 2;
        mem_val = 32'h0050_0093;
        i_addr = 32'h40;
        i_req = 1'b1;
        while (!got && cyc < 50) begin
            @(negedge clk);
            if (stall_if) st++;
            if (cyc == 1) begin
                checks++; if ({mem_req, mem_we, mem_addr, mem_wmask} !== {1'b1, 1'b0, 32'h40, 4'hF}) begin errors++; $display("FAIL fetch_mem_fields: got %h want %h", {mem_req, mem_we, mem_addr, mem_wmask}, {1'b1, 1'b0, 32'h40, 4'hF}); end
            end
            tick();
            cyc++;
            if (i_ack) got = 1;
        end
        checks++; if (cyc !== 3) begin errors++; $display("FAIL fetch_latency: got %0d want 3", cyc); end
        checks++; if (st !== 3) begin errors++; $display("FAIL fetch_stall_cycles: got %0d want 3", st); end
        checks++; if ({i_rdata, i_err, stall_if} !== {32'h0050_0093, 1'b0, 1'b0}) begin errors++; $display("FAIL fetch_result: got %h want %h", {i_rdata, i_err, stall_if}, {32'h0050_0093, 1'b0, 1'b0}); end
        i_req = 1'b0;
        tick();
        checks++; if ({i_ack, mem_req, i_rdata} !== {1'b0, 1'b0, 32'h0050_0093}) begin errors++; $display("FAIL fetch_after: got %h want %h", {i_ack, mem_req, i_rdata}, {1'b0, 1'b0, 32'h0050_0093}); end
    endtask

    task automatic test_simultaneous();
        int cyc = 0;
        int st = 0;
        int dcyc = -1;
        int icyc = -1;
        bit both = 0;
`ifdef MEM_PORT_ARB_PERF_EN
        logic [31:0] pc0 = perf_conflict;
        logic [31:0] pw0 = perf_i_wait;
`endif
        mem_lat = 1;
        mem_val = 32'h0000_0013;
        i_addr = 32'h80;
        d_we = 1'b1;
        d_addr = 32'h100;
        d_wdata = 32'hDEAD_BEEF;
        d_wmask = 4'hF;
        i_req = 1'b1;
        d_req = 1'b1;
        while (icyc < 0 && cyc < 50) begin
            @(negedge clk);
            if (stall_if) st++;
            if (cyc == 1) begin
                checks++; if ({mem_we, mem_addr, mem_wdata, mem_wmask} !== {1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF}) begin errors++; $display("FAIL simul_d_fields: got %h want %h", {mem_we, mem_addr, mem_wdata, mem_wmask}, {1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF}); end
            end
            if (cyc == 2) begin
                checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL simul_idle_gap: got mem_req=%b want 0", mem_req); end
            end
            if (cyc == 3) begin
                checks++; if ({mem_we, mem_addr, mem_wmask} !== {1'b0, 32'h80, 4'hF}) begin errors++; $display("FAIL simul_i_fields: got %h want %h", {mem_we, mem_addr, mem_wmask}, {1'b0, 32'h80, 4'hF}); end
            end
            tick();
            cyc++;
            if (i_ack && d_ack) both = 1;
            if (d_ack) begin
                dcyc = cyc;
                checks++; if ({d_rdata, d_err} !== {32'h0, 1'b0}) begin errors++; $display("FAIL simul_d_result: got %h want 0", {d_rdata, d_err}); end
                d_req = 1'b0;
            end
            if (i_ack) begin
                icyc = cyc;
                checks++; if ({i_rdata, i_err} !== {32'h13, 1'b0}) begin errors++; $display("FAIL simul_i_result: got %h want %h", {i_rdata, i_err}, {32'h13, 1'b0}); end
                i_req = 1'b0;
            end
        end
        d_we = 1'b0;
        checks++; if (dcyc !== 2) begin errors++; $display("FAIL simul_d_latency: got %0d want 2", dcyc); end
        checks++; if (icyc !== 4) begin errors++; $display("FAIL simul_i_latency: got %0d want 4", icyc); end
        checks++; if (both !== 1'b0) begin errors++; $display("FAIL simul_dual_ack: got %b want 0", both); end
        checks++; if (st !== 4) begin errors++; $display("FAIL simul_stall_cycles: got %0d want 4", st); end
`ifdef MEM_PORT_ARB_PERF_EN
        checks++; if (perf_conflict - pc0 !== 32'd1) begin errors++; $display("FAIL perf_conflict: got %0d want 1", perf_conflict - pc0); end
        checks++; if (perf_i_wait - pw0 !== 32'(st)) begin errors++; $display("FAIL perf_i_wait: got %0d want %0d", perf_i_wait - pw0, st); end
`endif
    endtask

    task automatic test_starvation();
        int cyc = 0;
        int n = 0;
        int icnt = 0;
        logic [7:0] seq = '0;
        bit both = 0;
        mem_lat = 1;
        mem_val = 32'hCAFE_0001;
        i_addr = 32'hC0;
        d_we = 1'b0;
        d_addr = 32'h180;
        i_req = 1'b1;
        d_req = 1'b1;
        while (icnt < 2 && cyc < 100) begin
            tick();
            cyc++;
            if (i_ack && d_ack) both = 1;
            if (i_ack || d_ack) begin
                seq = {seq[6:0], i_ack};
                n++;
            end
            if (i_ack) icnt++;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        checks++; if (n !== 8) begin errors++; $display("FAIL starve_ack_count: got %0d want 8", n); end
        checks++; if (seq !== 8'b0001_0001) begin errors++; $display("FAIL starve_order: got %b want 00010001", seq); end
        checks++; if (both !== 1'b0) begin errors++; $display("FAIL starve_dual_ack: got %b want 0", both); end
        tick();
    endtask

    task automatic test_timeout();
        int cyc = 0;
        bit got = 0;
`ifdef MEM_PORT_ARB_PERF_EN
        logic [31:0] pt0 = perf_timeout;
`endif
        mem_mute = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h200;
        d_req = 1'b1;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (cyc == 16) begin
                checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL timeout_last_busy: got mem_req=%b want 1", mem_req); end
            end
            tick();
            cyc++;
            if (d_ack) got = 1;
        end
        checks++; if (cyc !== 17) begin errors++; $display("FAIL timeout_latency: got %0d want 17", cyc); end
        checks++; if ({d_err, d_rdata, mem_req} !== {1'b1, 32'h0, 1'b0}) begin errors++; $display("FAIL timeout_result: got %h want %h", {d_err, d_rdata, mem_req}, {1'b1, 32'h0, 1'b0}); end
`ifdef MEM_PORT_ARB_PERF_EN
        checks++; if (perf_timeout - pt0 !== 32'd1) begin errors++; $display("FAIL perf_timeout: got %0d want 1", perf_timeout - pt0); end
`endif
        d_req = 1'b0;
        mem_mute = 1'b0;
        tick();
        mem_lat = 1;
        mem_val = 32'h1111_2222;
        d_addr = 32'h204;
        d_req = 1'b1;
        cyc = 0;
        got = 0;
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            if (d_ack) got = 1;
        end
        checks++; if (cyc !== 2) begin errors++; $display("FAIL after_timeout_latency: got %0d want 2", cyc); end
        checks++; if ({d_err, d_rdata} !== {1'b0, 32'h1111_2222}) begin errors++; $display("FAIL after_timeout_result: got %h want %h", {d_err, d_rdata}, {1'b0, 32'h1111_2222}); end
        d_req = 1'b0;
        tick();
        mem_lat = 16;
        mem_val = 32'h3333_4444;
        d_req = 1'b1;
        cyc = 0;
        got = 0;
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            if (d_ack) got = 1;
        end
        checks++; if (cyc !== 17) begin errors++; $display("FAIL late_ack_latency: got %0d want 17", cyc); end
        checks++; if ({d_err, d_rdata} !== {1'b0, 32'h3333_4444}) begin errors++; $display("FAIL late_ack_result: got %h want %h", {d_err, d_rdata}, {1'b0, 32'h3333_4444}); end
        d_req = 1'b0;
        mem_lat = 1;
        tick();
    endtask

    task automatic test_reset_busy();
        int cyc = 0;
        bit got = 0;
        bit seen = 0;
        mem_mute = 1'b1;
        i_addr = 32'h300;
        i_req = 1'b1;
        repeat (2) tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rbusy_pre: got mem_req=%b want 1", mem_req); end
        rst = 1'b0;
        #1;
        checks++; if ({mem_req, i_ack, i_rdata} !== {1'b0, 1'b0, 32'h0}) begin errors++; $display("FAIL rbusy_async: got %h want 0", {mem_req, i_ack, i_rdata}); end
        repeat (2) begin
            tick();
            if (i_ack || mem_req) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rbusy_held: got activity=%b want 0", seen); end
        mem_mute = 1'b0;
        mem_lat = 1;
        mem_val = 32'h0BAD_F00D;
        rst = 1'b1;
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            if (i_ack) got = 1;
        end
        checks++; if (cyc !== 2) begin errors++; $display("FAIL rbusy_reissue_latency: got %0d want 2", cyc); end
        checks++; if ({i_err, i_rdata, mem_addr} !== {1'b0, 32'h0BAD_F00D, 32'h300}) begin errors++; $display("FAIL rbusy_reissue_result: got %h want %h", {i_err, i_rdata, mem_addr}, {1'b0, 32'h0BAD_F00D, 32'h300}); end
        i_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
